// File: rtl/power_mult_scheduler_pkg.sv
// Shared constants for the matrix-power multiply scheduler: FSM state
// encoding and requester indices.
package power_mult_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_INC  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/power_mult_scheduler_if.sv
// Requester/datapath bundle of the scheduler. The master side is the
// requesting environment; the slave side is the scheduler itself.
interface power_mult_scheduler_if #(
  parameter int EW = 4
);

  logic          req0;
  logic          req1;
  logic [EW-1:0] exp0;
  logic [EW-1:0] exp1;
  logic          gnt0;
  logic          gnt1;
  logic          sel;
  logic          init;
  logic          inc;
  logic          ld_reg;
  logic          done0;
  logic          done1;
  logic          busy;
  logic [EW-1:0] step;

  modport master (
    output req0, req1, exp0, exp1,
    input  gnt0, gnt1, sel, init, inc, ld_reg, done0, done1, busy, step
  );

  modport slave (
    input  req0, req1, exp0, exp1,
    output gnt0, gnt1, sel, init, inc, ld_reg, done0, done1, busy, step
  );

endinterface

// File: rtl/power_mult_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. The pointer selects
// the winner only when both requests are present; it is stored by the parent.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick a one-hot winner from the two requests and the pointer.
  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/power_mult_scheduler.sv
// Sequencer and two-port arbiter for the shared matrix-power datapath.
// Grants the datapath round-robin, latches the clamped exponent of the
// winner, and walks init -> (inc, ld_reg) x e -> done. All outputs decode
// from registered state, so there is no path from req/exp to any output.
module power_mult_scheduler
  import power_mult_pkg::*;
#(
  parameter int EW    = 4,
  parameter int N_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  power_mult_scheduler_if.slave   bus
);

  localparam logic [EW-1:0] N_MAX_W = EW'(N_MAX);
  localparam logic [EW-1:0] ONE_W   = EW'(1);

  logic [2:0]    state;
  logic          owner;
  logic          ptr;
  logic [EW-1:0] e_q;
  logic [EW-1:0] step_q;

  logic [1:0]    arb_gnt;
  logic          any_req;
  logic          win_owner;
  logic [EW-1:0] exp_win;
  logic [EW-1:0] exp_clamped;

  rr_arbiter2 u_arb (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .ptr  (ptr),
    .gnt  (arb_gnt)
  );

  assign any_req     = bus.req0 | bus.req1;
  assign win_owner   = arb_gnt[1] ? REQ_1 : REQ_0;
  assign exp_win     = (win_owner == REQ_1) ? bus.exp1 : bus.exp0;
  assign exp_clamped = (exp_win > N_MAX_W) ? N_MAX_W : exp_win;

  // FSM, owner/exponent latch, step counter and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (rst) begin
      state  <= S_IDLE;
      owner  <= REQ_0;
      ptr    <= REQ_0;
      e_q    <= '0;
      step_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner  <= win_owner;
            e_q    <= exp_clamped;
            step_q <= '0;
            state  <= S_INIT;
          end
        end
        S_INIT: begin
          state <= (e_q == '0) ? S_DONE : S_INC;
        end
        S_INC: begin
          step_q <= step_q + ONE_W;
          state  <= S_MUL;
        end
        S_MUL: begin
          state <= (step_q == e_q) ? S_DONE : S_INC;
        end
        S_DONE: begin
          ptr   <= ~owner;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state and owner.
  assign bus.busy   = (state != S_IDLE);
  assign bus.gnt0   = bus.busy && (owner == REQ_0);
  assign bus.gnt1   = bus.busy && (owner == REQ_1);
  assign bus.sel    = bus.busy && (owner == REQ_1);
  assign bus.init   = (state == S_INIT);
  assign bus.inc    = (state == S_INC);
  assign bus.ld_reg = (state == S_MUL);
  assign bus.done0  = (state == S_DONE) && (owner == REQ_0);
  assign bus.done1  = (state == S_DONE) && (owner == REQ_1);
  assign bus.step   = step_q;

endmodule

// File: tb/tb_power_mult_scheduler.sv
// Directed bench for power_mult_scheduler. Each scenario task drives the
// request pins and compares the full output vector every cycle against the
// cycle-by-cycle operation schedule of the scheduler.
module tb_power_mult_scheduler;

  localparam int EW = 4;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  power_mult_scheduler_if #(.EW(EW)) bus ();

  power_mult_scheduler #(.EW(EW), .N_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector {gnt0,gnt1,sel,init,inc,ld_reg,done0,done1,busy}.
  function automatic logic [8:0] obs_vec();
    return {bus.gnt0, bus.gnt1, bus.sel, bus.init, bus.inc, bus.ld_reg,
            bus.done0, bus.done1, bus.busy};
  endfunction

  // Expected vector in cycle c (1 = INIT) of an operation by 'who' with
  // clamped exponent e; c outside 1..2+2e means idle.
  function automatic logic [8:0] exp_vec(input int who, input int e, input int c);
    logic b, g0, g1, s, in, ic, ld, d0, d1;
    int last;
    last = 2 + 2 * e;
    b  = (c >= 1) && (c <= last);
    g0 = b && (who == 0);
    g1 = b && (who == 1);
    s  = b && (who == 1);
    in = (c == 1);
    ic = (c >= 2) && (c < last) && (c % 2 == 0);
    ld = (c >= 3) && (c < last) && (c % 2 == 1);
    d0 = (c == last) && (who == 0);
    d1 = (c == last) && (who == 1);
    return {g0, g1, s, in, ic, ld, d0, d1, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.exp0 = '0;
    bus.exp1 = '0;
    tick();
    tick();
    vectors++;
    if (obs_vec() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want %b", obs_vec(), 9'b0);
    end
    vectors++;
    if (bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_step got %0d want 0", bus.step);
    end
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (obs_vec() !== 9'b0 || bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b step %0d want %b step 0",
               obs_vec(), bus.step, 9'b0);
    end
  endtask

  task automatic test_single();
    bus.exp0 = 4'd3;
    bus.req0 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec(0, 3, c)) begin
        miscompares++;
        $display("FAIL single c=%0d got %b want %b", c, obs_vec(), exp_vec(0, 3, c));
      end
      if (c == 8) begin
        vectors++;
        if (bus.step !== 4'd3) begin
          miscompares++;
          $display("FAIL single_step got %0d want 3", bus.step);
        end
        bus.req0 = 1'b0;
      end
    end
    tick();
    tick();
    vectors++;
    if (obs_vec() !== 9'b0) begin
      miscompares++;
      $display("FAIL single_idle got %b want %b", obs_vec(), 9'b0);
    end
  endtask

  task automatic test_exp_zero();
    bus.exp1 = 4'd0;
    bus.req1 = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec(1, 0, c)) begin
        miscompares++;
        $display("FAIL exp_zero c=%0d got %b want %b", c, obs_vec(), exp_vec(1, 0, c));
      end
      if (c == 2) begin
        vectors++;
        if (bus.step !== 4'd0) begin
          miscompares++;
          $display("FAIL exp_zero_step got %0d want 0", bus.step);
        end
        bus.req1 = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    bus.exp0 = 4'd15;
    bus.req0 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      // A late exponent change must not affect the running operation.
      if (c == 1) bus.exp0 = 4'd2;
      vectors++;
      if (obs_vec() !== exp_vec(0, 8, c)) begin
        miscompares++;
        $display("FAIL clamp c=%0d got %b want %b", c, obs_vec(), exp_vec(0, 8, c));
      end
      if (c == 18) begin
        vectors++;
        if (bus.step !== 4'd8) begin
          miscompares++;
          $display("FAIL clamp_step got %0d want 8", bus.step);
        end
        bus.req0 = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.exp0 = 4'd1;
    bus.exp1 = 4'd1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        vectors++;
        if (obs_vec() !== exp_vec(op % 2, 1, c)) begin
          miscompares++;
          $display("FAIL b2b op=%0d c=%0d got %b want %b", op, c, obs_vec(),
                   exp_vec(op % 2, 1, c));
        end
        if (op == 3 && c == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
      tick();
      vectors++;
      if (obs_vec() !== 9'b0) begin
        miscompares++;
        $display("FAIL b2b_gap op=%0d got %b want %b", op, obs_vec(), 9'b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Quick op by requester 0 leaves the pointer favouring requester 1.
    bus.exp0 = 4'd0;
    bus.req0 = 1'b1;
    tick();
    tick();
    bus.req0 = 1'b0;
    tick();
    bus.exp1 = 4'd3;
    bus.req1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec(1, 3, c)) begin
        miscompares++;
        $display("FAIL rstmid_pre c=%0d got %b want %b", c, obs_vec(), exp_vec(1, 3, c));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req1 = 1'b0;
    vectors++;
    if (obs_vec() !== 9'b0 || bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL rstmid_clear got %b step %0d want %b step 0",
               obs_vec(), bus.step, 9'b0);
    end
    tick();
    vectors++;
    if (obs_vec() !== 9'b0) begin
      miscompares++;
      $display("FAIL rstmid_nodone got %b want %b", obs_vec(), 9'b0);
    end
    bus.exp0 = 4'd1;
    bus.exp1 = 4'd1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec(0, 1, c)) begin
        miscompares++;
        $display("FAIL rstmid_post c=%0d got %b want %b", c, obs_vec(), exp_vec(0, 1, c));
      end
      if (c == 4) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_drop_mid();
    bus.exp0 = 4'd2;
    bus.req0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) bus.req0 = 1'b0;
      vectors++;
      if (obs_vec() !== exp_vec(0, 2, c)) begin
        miscompares++;
        $display("FAIL drop_mid c=%0d got %b want %b", c, obs_vec(), exp_vec(0, 2, c));
      end
    end
    tick();
    vectors++;
    if (obs_vec() !== 9'b0) begin
      miscompares++;
      $display("FAIL drop_mid_idle got %b want %b", obs_vec(), 9'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.exp0    = '0;
    bus.exp1    = '0;
    test_reset();
    test_single();
    test_exp_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_drop_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
